// File: rtl/cg_pkg.sv
// Shared definitions for the CG vector datapath: row geometry and bank FSM states.
package cg_pkg;

  localparam int ELEMENT_WIDTH = 32;
  localparam int NO_OF_UNITS   = 8;

  // LOAD: the read bank holds nothing usable yet. RUN: the read bank is valid.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } cg_state_e;

endpackage

// File: rtl/cg_row_ram.sv
// Single-port row RAM with a registered read port. A write takes the port for
// that cycle; otherwise a read enable loads the output register, which holds
// its value between reads and clears on reset (the array itself is not reset).
module cg_row_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1000,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cg_vector_bank.sv
// Double-buffered vector bank for the CG solver. One bank is filled row by row
// from the ALU result path while the other is streamed out; a swap pulse at the
// end of an iteration exchanges their roles once the fill is complete.
module cg_vector_bank
  import cg_pkg::*;
#(
  parameter int ELEMENT_WIDTH = cg_pkg::ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = cg_pkg::NO_OF_UNITS,
  parameter int MEMORY_HEIGHT = 1000,
  parameter int ADDR_WIDTH    = $clog2(MEMORY_HEIGHT) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          total,
  input  logic                                 wr_en,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
  input  logic                                 rd_strobe,
  input  logic                                 swap,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
  output logic                                 rd_valid,
  output logic                                 rd_wrap,
  output logic                                 wr_done,
  output logic                                 readable,
  output logic                                 overflow,
  output logic                                 swap_error
);

  localparam int ROW_W  = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int RAM_AW = (MEMORY_HEIGHT > 1) ? $clog2(MEMORY_HEIGHT) : 1;

  cg_state_e             state_q, state_d;
  logic                  bank_sel;
  logic                  rd_bank_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_after, rd_ptr_inc;
  logic [31:0]           rows_raw;
  logic [ADDR_WIDTH-1:0] rows;
  logic                  wr_accept, swap_ok, rd_accept;
  logic                  we0, we1, re0, re1;
  logic [RAM_AW-1:0]     addr0, addr1;
  logic [ROW_W-1:0]      q0, q1;

  // Row count from the element count; clamped so a bad length cannot run the
  // pointers past the physical bank depth.
  assign rows_raw = total / 32'(NO_OF_UNITS);
  assign rows     = (rows_raw > 32'(MEMORY_HEIGHT)) ? ADDR_WIDTH'(MEMORY_HEIGHT)
                                                    : rows_raw[ADDR_WIDTH-1:0];

  // A same-cycle write counts toward completion before the swap is judged.
  assign wr_accept    = wr_en && (wr_ptr < rows);
  assign wr_ptr_after = wr_ptr + ADDR_WIDTH'(wr_accept);
  assign swap_ok      = swap && (wr_ptr_after == rows);
  assign rd_accept    = rd_strobe && (state_q == RUN);
  assign rd_ptr_inc   = rd_ptr + ADDR_WIDTH'(1);

  assign wr_done  = (wr_ptr == rows);
  assign readable = (state_q == RUN);

  // Bank 0 is written when bank_sel=1 and read when bank_sel=0; bank 1 mirrors it.
  assign we0   = wr_accept && bank_sel && !reset;
  assign re0   = rd_accept && !bank_sel && !reset;
  assign we1   = wr_accept && !bank_sel && !reset;
  assign re1   = rd_accept && bank_sel && !reset;
  assign addr0 = bank_sel ? wr_ptr[RAM_AW-1:0] : rd_ptr[RAM_AW-1:0];
  assign addr1 = bank_sel ? rd_ptr[RAM_AW-1:0] : wr_ptr[RAM_AW-1:0];

  cg_row_ram #(.WIDTH(ROW_W), .DEPTH(MEMORY_HEIGHT), .AW(RAM_AW)) u_bank0 (
    .clk(clk), .reset(reset), .we(we0), .re(re0),
    .addr(addr0), .wdata(wr_data), .rdata(q0)
  );

  cg_row_ram #(.WIDTH(ROW_W), .DEPTH(MEMORY_HEIGHT), .AW(RAM_AW)) u_bank1 (
    .clk(clk), .reset(reset), .we(we1), .re(re1),
    .addr(addr1), .wdata(wr_data), .rdata(q1)
  );

  // The output follows whichever bank served the most recent read.
  assign rd_data = rd_bank_q ? q1 : q0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only an accepted swap moves LOAD to RUN; RUN is permanent.
  always_comb begin
    state_d = state_q;
    if (swap_ok) begin
      state_d = RUN;
    end
  end

  // Pointers, bank select, read handshake and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel   <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      rd_wrap    <= 1'b0;
      overflow   <= 1'b0;
      swap_error <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      rd_wrap  <= rd_accept && (rd_ptr_inc == rows);
      if (rd_accept) begin
        rd_bank_q <= bank_sel;
      end
      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (swap && !swap_ok) begin
        swap_error <= 1'b1;
      end
      if (swap_ok) begin
        bank_sel <= ~bank_sel;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        wr_ptr <= wr_ptr_after;
        if (rd_accept) begin
          rd_ptr <= (rd_ptr_inc >= rows) ? '0 : rd_ptr_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cg_vector_bank.sv
// Directed bench for cg_vector_bank: a per-cycle vector table for the main
// fill/swap/stream flow plus hand-written sequences for the corner cases.
module tb_cg_vector_bank;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int RW = EW * NU;

  logic          clk;
  logic          reset;
  logic [31:0]   total;
  logic          wr_en;
  logic [RW-1:0] wr_data;
  logic          rd_strobe;
  logic          swap;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_wrap;
  logic          wr_done;
  logic          readable;
  logic          overflow;
  logic          swap_error;

  int n_checks;
  int n_pass;

  cg_vector_bank dut (
    .clk(clk), .reset(reset), .total(total),
    .wr_en(wr_en), .wr_data(wr_data), .rd_strobe(rd_strobe), .swap(swap),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_wrap(rd_wrap),
    .wr_done(wr_done), .readable(readable),
    .overflow(overflow), .swap_error(swap_error)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] tag;
    logic        rd;
    logic        sw;
    logic        exp_valid;
    logic        exp_wrap;
    logic [31:0] exp_tag;
    logic        exp_readable;
    logic        exp_wr_done;
  } vec_t;

  vec_t vecs[18];

  // Row pattern: element i carries tag+i; tag 0 means the all-zero row.
  function automatic logic [RW-1:0] make_row(input logic [31:0] t);
    logic [RW-1:0] r;
    r = '0;
    if (t != 0) begin
      for (int i = 0; i < NU; i++) r[i*EW +: EW] = t + 32'(i);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] tag, input logic rd,
                              input logic sw, input logic ev, input logic ew,
                              input logic [31:0] et, input logic er, input logic ed);
    vec_t v;
    v.wr = wr; v.tag = tag; v.rd = rd; v.sw = sw;
    v.exp_valid = ev; v.exp_wrap = ew; v.exp_tag = et;
    v.exp_readable = er; v.exp_wr_done = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] actual,
                             input logic [RW-1:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then return the strobes to idle.
  task automatic applyStimulus(input logic wr, input logic [31:0] tag,
                               input logic rd, input logic sw);
    wr_en     = wr;
    wr_data   = make_row(tag);
    rd_strobe = rd;
    swap      = sw;
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    rd_strobe = 1'b0;
    swap      = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    wr_en = 1'b0; rd_strobe = 1'b0; swap = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    total     = 32'd32;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_strobe = 1'b0;
    swap      = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    doReset();
    checkOutput("reset_readable", RW'(readable), RW'(0));
    checkOutput("reset_rd_valid", RW'(rd_valid), RW'(0));
    checkOutput("reset_rd_wrap", RW'(rd_wrap), RW'(0));
    checkOutput("reset_rd_data", rd_data, '0);
    checkOutput("reset_overflow", RW'(overflow), RW'(0));
    checkOutput("reset_swap_error", RW'(swap_error), RW'(0));
    checkOutput("reset_wr_done", RW'(wr_done), RW'(0));

    // Main flow, total=32 (4 rows): fill, swap, stream 5 rows, refill while
    // paused at row 1, then read and swap in the same cycle.
    vecs[0]  = mk(1, 32'hA0, 0, 0, 0, 0, 32'h00, 0, 0);
    vecs[1]  = mk(1, 32'hB0, 0, 0, 0, 0, 32'h00, 0, 0);
    vecs[2]  = mk(1, 32'hC0, 0, 0, 0, 0, 32'h00, 0, 0);
    vecs[3]  = mk(1, 32'hD0, 0, 0, 0, 0, 32'h00, 0, 1);
    vecs[4]  = mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 1, 0);
    vecs[5]  = mk(0, 32'h00, 1, 0, 1, 0, 32'hA0, 1, 0);
    vecs[6]  = mk(0, 32'h00, 1, 0, 1, 0, 32'hB0, 1, 0);
    vecs[7]  = mk(0, 32'h00, 1, 0, 1, 0, 32'hC0, 1, 0);
    vecs[8]  = mk(0, 32'h00, 1, 0, 1, 1, 32'hD0, 1, 0);
    vecs[9]  = mk(0, 32'h00, 1, 0, 1, 0, 32'hA0, 1, 0);
    vecs[10] = mk(0, 32'h00, 0, 0, 0, 0, 32'hA0, 1, 0);
    vecs[11] = mk(1, 32'hE0, 0, 0, 0, 0, 32'hA0, 1, 0);
    vecs[12] = mk(1, 32'hF0, 0, 0, 0, 0, 32'hA0, 1, 0);
    vecs[13] = mk(1, 32'h1A0, 0, 0, 0, 0, 32'hA0, 1, 0);
    vecs[14] = mk(1, 32'h1B0, 0, 0, 0, 0, 32'hA0, 1, 1);
    vecs[15] = mk(0, 32'h00, 1, 1, 1, 0, 32'hB0, 1, 0);
    vecs[16] = mk(0, 32'h00, 1, 0, 1, 0, 32'hE0, 1, 0);
    vecs[17] = mk(0, 32'h00, 0, 0, 0, 0, 32'hE0, 1, 0);

    total = 32'd32;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].tag, vecs[i].rd, vecs[i].sw);
      checkOutput($sformatf("v%0d_rd_valid", i), RW'(rd_valid), RW'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_rd_wrap", i), RW'(rd_wrap), RW'(vecs[i].exp_wrap));
      checkOutput($sformatf("v%0d_rd_data", i), rd_data, make_row(vecs[i].exp_tag));
      checkOutput($sformatf("v%0d_readable", i), RW'(readable), RW'(vecs[i].exp_readable));
      checkOutput($sformatf("v%0d_wr_done", i), RW'(wr_done), RW'(vecs[i].exp_wr_done));
      checkOutput($sformatf("v%0d_flags", i), RW'({overflow, swap_error}), RW'(0));
    end

    // Reset with a read strobe in the same cycle drops the read.
    reset = 1'b1;
    rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_strobe = 1'b0;
    checkOutput("midread_rd_valid", RW'(rd_valid), RW'(0));
    checkOutput("midread_rd_data", rd_data, '0);
    checkOutput("midread_readable", RW'(readable), RW'(0));

    // Early swap is rejected; completing the fill lets the next swap through.
    doReset();
    total = 32'd32;
    applyStimulus(1, 32'h310, 0, 0);
    applyStimulus(1, 32'h320, 0, 0);
    applyStimulus(1, 32'h330, 0, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("early_swap_error", RW'(swap_error), RW'(1));
    checkOutput("early_readable", RW'(readable), RW'(0));
    applyStimulus(1, 32'h340, 0, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("late_swap_readable", RW'(readable), RW'(1));
    checkOutput("late_swap_error_sticky", RW'(swap_error), RW'(1));
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("late_swap_row0", rd_data, make_row(32'h310));
    checkOutput("late_swap_valid", RW'(rd_valid), RW'(1));

    // Last write and swap in the same cycle: the write counts toward completion.
    doReset();
    applyStimulus(1, 32'h410, 0, 0);
    applyStimulus(1, 32'h420, 0, 0);
    applyStimulus(1, 32'h430, 0, 0);
    applyStimulus(1, 32'h440, 0, 1);
    checkOutput("wrswap_readable", RW'(readable), RW'(1));
    checkOutput("wrswap_error", RW'(swap_error), RW'(0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 1, 0);
      checkOutput($sformatf("wrswap_row%0d", i), rd_data, make_row(32'h410 + 32'(i) * 32'h10));
      checkOutput($sformatf("wrswap_wrap%0d", i), RW'(rd_wrap), RW'(i == 3));
    end

    // Overflow: total=16 gives 2 rows; the third write is dropped.
    doReset();
    total = 32'd16;
    applyStimulus(1, 32'h510, 0, 0);
    applyStimulus(1, 32'h520, 0, 0);
    checkOutput("ovf_before", RW'(overflow), RW'(0));
    applyStimulus(1, 32'h530, 0, 0);
    checkOutput("ovf_set", RW'(overflow), RW'(1));
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("ovf_readable", RW'(readable), RW'(1));
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("ovf_rd0", rd_data, make_row(32'h510));
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("ovf_rd1", rd_data, make_row(32'h520));
    checkOutput("ovf_wrap1", RW'(rd_wrap), RW'(1));
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("ovf_rd2", rd_data, make_row(32'h510));

    // Zero rows (total=7 floors to 0): done immediately, swap accepted.
    doReset();
    total = 32'd7;
    #1;
    checkOutput("zero_wr_done", RW'(wr_done), RW'(1));
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("zero_readable", RW'(readable), RW'(1));
    checkOutput("zero_swap_error", RW'(swap_error), RW'(0));

    // Reset mid-fill after 2 of 4 writes, with a sticky flag set beforehand.
    doReset();
    total = 32'd32;
    applyStimulus(1, 32'h610, 0, 0);
    applyStimulus(1, 32'h620, 0, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("midfill_pre_error", RW'(swap_error), RW'(1));
    doReset();
    checkOutput("midfill_readable", RW'(readable), RW'(0));
    checkOutput("midfill_wr_done", RW'(wr_done), RW'(0));
    checkOutput("midfill_flags", RW'({overflow, swap_error}), RW'(0));
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h710 + 32'(i) * 32'h10, 0, 0);
    checkOutput("refill_wr_done", RW'(wr_done), RW'(1));
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("refill_readable", RW'(readable), RW'(1));
    checkOutput("refill_error", RW'(swap_error), RW'(0));
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("refill_row0", rd_data, make_row(32'h710));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
